// File: rtl/pipe_mw_vec_pkg.sv
// Shared types for the vector MEM/WB stage: occupancy encoding, the captured
// entry layout and the per-lane write-back result select.
package pipe_pkg;

    localparam int WIDTH = 32;
    localparam int LANES = 4;
    localparam int RA_W  = 5;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        FULL  = 2'd2
    } occ_e;

    typedef struct packed {
        logic                   reg_write;
        logic                   mem_to_reg;
        logic [LANES-1:0]       lane_mask;
        logic [RA_W-1:0]        rd;
        logic [LANES*WIDTH-1:0] mem_rd;
        logic [LANES*WIDTH-1:0] alu_out;
        logic [LANES*WIDTH-1:0] result;
    } mw_entry_t;

    // The select is independent of lane_mask: masked lanes still carry a result.
    function automatic logic [LANES*WIDTH-1:0] sel_result(
        input logic                   mem_to_reg,
        input logic [LANES*WIDTH-1:0] mem_rd,
        input logic [LANES*WIDTH-1:0] alu_out
    );
        logic [LANES*WIDTH-1:0] r;
        r = '0;
        for (int i = 0; i < LANES; i++) begin
            r[i*WIDTH +: WIDTH] = mem_to_reg ? mem_rd[i*WIDTH +: WIDTH]
                                             : alu_out[i*WIDTH +: WIDTH];
        end
        return r;
    endfunction

endpackage

// File: rtl/pipe_mw_vec_if.sv
// Memory-side and write-back-side signals of the MEM/WB stage. The slave
// modport is the stage itself; master is the surrounding pipeline.
interface pipe_mw_vec_if;
    import pipe_pkg::*;

    // Handshake: a transfer happens on a rising edge where valid and ready are
    // both high; valid must not depend on ready, and ready comes from state only.
    logic                   VALID_M;
    logic                   READY_M;
    logic                   REG_WRITE_M;
    logic                   MEM_TO_REG_M;
    logic [LANES-1:0]       LANE_MASK_M;
    logic [RA_W-1:0]        RD_M;
    logic [LANES*WIDTH-1:0] MEM_RD_M;
    logic [LANES*WIDTH-1:0] ALU_OUT_M;

    logic                   VALID_W;
    logic                   READY_W;
    logic                   REG_WRITE_W;
    logic                   MEM_TO_REG_W;
    logic [LANES-1:0]       LANE_MASK_W;
    logic [RA_W-1:0]        RD_W;
    logic [LANES*WIDTH-1:0] MEM_RD_W;
    logic [LANES*WIDTH-1:0] ALU_OUT_W;
    logic [LANES*WIDTH-1:0] RESULT_W;

    modport slave (
        input  VALID_M, REG_WRITE_M, MEM_TO_REG_M, LANE_MASK_M, RD_M, MEM_RD_M, ALU_OUT_M,
        output READY_M,
        output VALID_W, REG_WRITE_W, MEM_TO_REG_W, LANE_MASK_W, RD_W, MEM_RD_W, ALU_OUT_W,
        output RESULT_W,
        input  READY_W
    );

    modport master (
        output VALID_M, REG_WRITE_M, MEM_TO_REG_M, LANE_MASK_M, RD_M, MEM_RD_M, ALU_OUT_M,
        input  READY_M,
        input  VALID_W, REG_WRITE_W, MEM_TO_REG_W, LANE_MASK_W, RD_W, MEM_RD_W, ALU_OUT_W,
        input  RESULT_W,
        output READY_W
    );

endinterface

// File: rtl/pipe_skid_buf.sv
// Two-entry elastic buffer over an opaque payload. src_ready comes from the
// occupancy register only, so no combinational path from dst_ready exists.
module pipe_skid_buf
    import pipe_pkg::*;
#(
    parameter int PW = 8
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          flush,
    input  logic          src_valid,
    output logic          src_ready,
    input  logic [PW-1:0] src_data,
    output logic          dst_valid,
    input  logic          dst_ready,
    output logic [PW-1:0] dst_data,
    output logic [1:0]    state
);

    localparam logic [1:0] S_EMPTY = EMPTY;
    localparam logic [1:0] S_ONE   = ONE;
    localparam logic [1:0] S_FULL  = FULL;

    logic [PW-1:0] head;
    logic [PW-1:0] skid;
    logic          push;
    logic          pop;

    assign src_ready = (state != S_FULL);
    assign dst_valid = (state != S_EMPTY);
    assign dst_data  = head;
    assign push      = src_valid & src_ready & ~flush;
    assign pop       = dst_valid & dst_ready;

    // head is never cleared on pop or flush so outputs hold their last value.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= S_EMPTY;
            head  <= '0;
            skid  <= '0;
        end else if (flush) begin
            state <= S_EMPTY;
        end else begin
            case (state)
                S_EMPTY: begin
                    if (push) begin
                        head  <= src_data;
                        state <= S_ONE;
                    end
                end
                S_ONE: begin
                    if (push && !pop) begin
                        skid  <= src_data;
                        state <= S_FULL;
                    end else if (push && pop) begin
                        head  <= src_data;
                    end else if (pop) begin
                        state <= S_EMPTY;
                    end
                end
                S_FULL: begin
                    if (pop) begin
                        head  <= skid;
                        state <= S_ONE;
                    end
                end
                default: state <= S_EMPTY;
            endcase
        end
    end

endmodule

// File: rtl/pipe_mw_vec.sv
// Vector MEM/WB stage: captures LANES result words plus control per entry into
// a skid buffer and gates the register-file write controls with VALID_W.
module pipe_mw_vec
    import pipe_pkg::*;
(
    input  logic                 CLK,
    input  logic                 CLR,
    input  logic                 FLUSH,
    pipe_mw_vec_if.slave         bus,
    output occ_e                 occ
);

    mw_entry_t  cap;
    mw_entry_t  head;
    logic [1:0] state;

    // The write-back mux is resolved at capture so RESULT_W is a plain register.
    always_comb begin
        cap            = '0;
        cap.reg_write  = bus.REG_WRITE_M;
        cap.mem_to_reg = bus.MEM_TO_REG_M;
        cap.lane_mask  = bus.LANE_MASK_M;
        cap.rd         = bus.RD_M;
        cap.mem_rd     = bus.MEM_RD_M;
        cap.alu_out    = bus.ALU_OUT_M;
        cap.result     = sel_result(bus.MEM_TO_REG_M, bus.MEM_RD_M, bus.ALU_OUT_M);
    end

    pipe_skid_buf #(
        .PW($bits(mw_entry_t))
    ) u_buf (
        .clk       (CLK),
        .rst       (CLR),
        .flush     (FLUSH),
        .src_valid (bus.VALID_M),
        .src_ready (bus.READY_M),
        .src_data  (cap),
        .dst_valid (bus.VALID_W),
        .dst_ready (bus.READY_W),
        .dst_data  (head),
        .state     (state)
    );

    // A stale head must never reach the register file.
    assign bus.REG_WRITE_W  = head.reg_write & bus.VALID_W;
    assign bus.LANE_MASK_W  = bus.VALID_W ? head.lane_mask : '0;
    assign bus.MEM_TO_REG_W = head.mem_to_reg;
    assign bus.RD_W         = head.rd;
    assign bus.MEM_RD_W     = head.mem_rd;
    assign bus.ALU_OUT_W    = head.alu_out;
    assign bus.RESULT_W     = head.result;
    assign occ              = occ_e'(state);

endmodule

// File: tb/tb_pipe_mw_vec.sv
// Bench for pipe_mw_vec: directed scenarios plus random traffic, all checked
// against an in-order queue model of at most two buffered entries.
module tb_pipe_mw_vec;
    import pipe_pkg::*;

    localparam int DW = LANES * WIDTH;
    localparam int EW = 2 + LANES + RA_W + 2 * DW;

    logic clk = 1'b0;
    logic clr;
    logic flush;
    occ_e occ;

    always #5 clk = ~clk;

    pipe_mw_vec_if bus();

    pipe_mw_vec dut (
        .CLK   (clk),
        .CLR   (clr),
        .FLUSH (flush),
        .bus   (bus.slave),
        .occ   (occ)
    );

    int n_checks = 0;
    int n_pass   = 0;

    logic [EW-1:0] exp_q[$];
    logic [EW-1:0] last_ent;

    task automatic check(input string tag, input logic [255:0] got, input logic [255:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    endtask

    function automatic logic [DW-1:0] rand_word();
        logic [DW-1:0] w;
        w = '0;
        for (int i = 0; i < LANES; i++) w[i*WIDTH +: WIDTH] = WIDTH'($urandom);
        return w;
    endfunction

    // With the queue empty the data outputs show the last head that was displayed.
    task automatic check_outputs();
        logic [EW-1:0]    e;
        logic             vld, rw, m2r;
        logic [LANES-1:0] mask;
        logic [RA_W-1:0]  rd;
        logic [DW-1:0]    mem, alu, res;
        vld = (exp_q.size() > 0);
        e   = vld ? exp_q[0] : last_ent;
        {rw, m2r, mask, rd, mem, alu} = e;
        for (int i = 0; i < LANES; i++)
            res[i*WIDTH +: WIDTH] = m2r ? mem[i*WIDTH +: WIDTH] : alu[i*WIDTH +: WIDTH];
        check("valid_w",      256'(bus.VALID_W),      256'(vld));
        check("ready_m",      256'(bus.READY_M),      256'(exp_q.size() < 2));
        check("occ",          256'(occ),              256'(exp_q.size()));
        check("reg_write_w",  256'(bus.REG_WRITE_W),  256'(vld & rw));
        check("lane_mask_w",  256'(bus.LANE_MASK_W),  256'(vld ? mask : '0));
        check("mem_to_reg_w", 256'(bus.MEM_TO_REG_W), 256'(m2r));
        check("rd_w",         256'(bus.RD_W),         256'(rd));
        check("mem_rd_w",     256'(bus.MEM_RD_W),     256'(mem));
        check("alu_out_w",    256'(bus.ALU_OUT_W),    256'(alu));
        check("result_w",     256'(bus.RESULT_W),     256'(res));
    endtask

    task automatic step(input logic v, input logic rw, input logic m2r,
                        input logic [LANES-1:0] mask, input logic [RA_W-1:0] rd,
                        input logic rdy, input logic fl, input logic cl);
        logic [DW-1:0] mem, alu;
        logic          pop, push;
        mem = rand_word();
        alu = rand_word();
        bus.VALID_M      = v;
        bus.REG_WRITE_M  = rw;
        bus.MEM_TO_REG_M = m2r;
        bus.LANE_MASK_M  = mask;
        bus.RD_M         = rd;
        bus.MEM_RD_M     = mem;
        bus.ALU_OUT_M    = alu;
        bus.READY_W      = rdy;
        flush            = fl;
        clr              = cl;
        @(posedge clk);
        pop  = (exp_q.size() > 0) && rdy;
        push = v && (exp_q.size() < 2) && !fl && !cl;
        if (cl) begin
            exp_q.delete();
            last_ent = '0;
        end else if (fl) begin
            exp_q.delete();
        end else begin
            if (pop) void'(exp_q.pop_front());
            if (push) exp_q.push_back({rw, m2r, mask, rd, mem, alu});
        end
        if (exp_q.size() > 0) last_ent = exp_q[0];
        #1;
        check_outputs();
    endtask

    task automatic idle();
        step(1'b0, 1'b0, 1'b0, '0, '0, 1'b1, 1'b0, 1'b0);
    endtask

    initial begin
        last_ent = '0;
        bus.VALID_M = 1'b0; bus.REG_WRITE_M = 1'b0; bus.MEM_TO_REG_M = 1'b0;
        bus.LANE_MASK_M = '0; bus.RD_M = '0; bus.MEM_RD_M = '0; bus.ALU_OUT_M = '0;
        bus.READY_W = 1'b0; flush = 1'b0; clr = 1'b1;

        // Reset with live-looking traffic on the inputs
        repeat (2) step(1'b1, 1'($urandom), 1'($urandom), LANES'($urandom), RA_W'($urandom),
                        1'($urandom), 1'b0, 1'b1);
        idle();
        check("ready_m_after_clr", 256'(bus.READY_M), 256'(1));

        // Streaming, one entry per cycle
        for (int k = 1; k <= 10; k++) begin
            step(1'b1, 1'b1, 1'(k % 2), {LANES{1'b1}}, RA_W'(k), 1'b1, 1'b0, 1'b0);
            check("stream_rd", 256'(bus.RD_W), 256'(k));
        end
        idle();

        // Backpressure: entry 2 absorbed, entry 3 held off until space frees
        step(1'b1, 1'b1, 1'b0, '1, 5'd1, 1'b1, 1'b0, 1'b0);
        step(1'b1, 1'b1, 1'b1, '1, 5'd2, 1'b0, 1'b0, 1'b0);
        check("bp_full_ready", 256'(bus.READY_M), 256'(0));
        step(1'b1, 1'b1, 1'b0, '1, 5'd3, 1'b0, 1'b0, 1'b0);
        step(1'b1, 1'b1, 1'b0, '1, 5'd3, 1'b1, 1'b0, 1'b0);
        check("bp_rd2", 256'(bus.RD_W), 256'(2));
        step(1'b1, 1'b1, 1'b0, '1, 5'd3, 1'b1, 1'b0, 1'b0);
        check("bp_rd3", 256'(bus.RD_W), 256'(3));
        idle();

        // Push and pop together in ONE
        step(1'b1, 1'b1, 1'b0, '1, 5'd5, 1'b0, 1'b0, 1'b0);
        step(1'b1, 1'b1, 1'b1, '1, 5'd6, 1'b1, 1'b0, 1'b0);
        check("pp_rd6", 256'(bus.RD_W), 256'(6));
        idle();

        // Flush from FULL with a simultaneous push
        step(1'b1, 1'b1, 1'b0, '1, 5'd7, 1'b0, 1'b0, 1'b0);
        step(1'b1, 1'b1, 1'b0, '1, 5'd8, 1'b0, 1'b0, 1'b0);
        step(1'b1, 1'b1, 1'b0, '1, 5'd9, 1'b0, 1'b1, 1'b0);
        check("flush_valid", 256'(bus.VALID_W), 256'(0));
        idle();
        check("flush_no_rd9", 256'(bus.VALID_W), 256'(0));

        // Mask gating after the last pop
        step(1'b1, 1'b1, 1'b0, 4'b1010, 5'd11, 1'b0, 1'b0, 1'b0);
        check("mask_live", 256'(bus.LANE_MASK_W), 256'(4'b1010));
        idle();
        check("mask_gated", 256'(bus.LANE_MASK_W), 256'(0));

        // Random traffic with occasional flush and clear
        repeat (400) begin
            step(1'($urandom_range(0, 3) != 0), 1'($urandom), 1'($urandom),
                 LANES'($urandom), RA_W'($urandom), 1'($urandom_range(0, 2) != 0),
                 1'($urandom_range(0, 15) == 0), 1'($urandom_range(0, 63) == 0));
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
